// File: rtl/delay_pkg.sv
// delay_pkg: shared constants and helpers for the programmable delay line
package delay_pkg;
  localparam int BYPASS_DELAY = 0;
  function automatic int dw_for(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
  function automatic int clamp_delay(input int value, input int lim);
    return value > lim ? lim : value;
  endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one data+valid register with enable and synchronous valid clear
module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             qv
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (clr) begin
      qv <= 1'b0;
    end else if (en) begin
      q  <= d;
      qv <= dv;
    end
  end
endmodule

// File: rtl/delay_line.sv
// delay_line: run-time programmable delay of a data word and its valid bit
module delay_line import delay_pkg::*; #(
  parameter  int WIDTH         = 8,
  parameter  int MAX_DEPTH     = 16,
  parameter  int DEFAULT_DELAY = 1,
  localparam int DW            = dw_for(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [DW-1:0]    delay,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             primed
);
  logic [DW-1:0]    delay_c, delay_r, fill_cnt;
  logic [WIDTH-1:0] s [0:MAX_DEPTH];
  logic             v [0:MAX_DEPTH];
  logic             clr, shift;
  always_comb begin
    delay_c = DW'(clamp_delay(int'(delay), MAX_DEPTH));
    clr     = flush | (delay_c != delay_r);
    shift   = en & ~clr;
  end
  // slot 0 is the live input so index 0 of the output mux is bypass
  assign s[0] = d;
  assign v[0] = d_valid;
  for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (clk),
      .reset(reset),
      .en   (shift),
      .clr  (clr),
      .d    (s[k-1]),
      .dv   (v[k-1]),
      .q    (s[k]),
      .qv   (v[k])
    );
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      delay_r  <= DW'(DEFAULT_DELAY);
      fill_cnt <= '0;
    end else if (clr) begin
      fill_cnt <= '0;
      if (!flush) delay_r <= delay_c;
    end else if (en && fill_cnt != DW'(MAX_DEPTH)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end
  assign q       = s[delay_r];
  assign q_valid = v[delay_r];
  assign primed  = (delay_r == DW'(BYPASS_DELAY)) || (fill_cnt >= delay_r);
endmodule
